// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
// Shares one byte-wide UART transmitter between two fixed-length frame
// requesters (A = clock sync, B = status/debug). Grants one requester per
// frame, round-robin, serialises the latched frame low byte first, and then
// holds an idle gap before the next grant.
//
// Transmitter handshake: a byte is offered only while tx_busy is low, by a
// single-cycle tx_send strobe with tx_data stable in that cycle. The
// transmitter acknowledges by raising tx_busy; the byte counts as sent when
// tx_busy falls again. If tx_busy never rises within BUSY_TIMEOUT cycles the
// frame is aborted with an err pulse and its requester competes again.
module uart_frame_arbiter #(
   parameter int N_BYTES      = 7,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_a,
   input  logic [8*N_BYTES-1:0]   frame_a,
   input  logic                   req_b,
   input  logic [8*N_BYTES-1:0]   frame_b,
   input  logic                   tx_busy,
   output logic [7:0]             tx_data,
   output logic                   tx_send,
   output logic [1:0]             grant,
   output logic                   done_a,
   output logic                   done_b,
   output logic                   err,
   output logic                   active
);

   localparam int FW  = 8 * N_BYTES;
   localparam int BCW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int TCW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BCW-1:0] BYTE_LAST = BCW'(N_BYTES - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // last_served encoding: which requester owned the previous frame
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND      = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [FW-1:0]   shift, shift_n;
   logic [BCW-1:0]  byte_cnt, byte_cnt_n;
   logic [TCW-1:0]  to_cnt, to_cnt_n;
   logic [GCW-1:0]  gap_cnt, gap_cnt_n;
   logic            last_served, last_n;

   logic [7:0]      tx_data_n;
   logic            tx_send_n;
   logic [1:0]      grant_n;
   logic            done_a_n;
   logic            done_b_n;
   logic            err_n;
   logic            active_n;

   logic            pick_a;
   logic            gap_over;

   // A wins when alone, or on a tie when B owned the previous frame
   assign pick_a   = req_a && (!req_b || (last_served == SEL_B));
   // a zero gap still spends the one GAP cycle and returns on the next edge
   assign gap_over = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);

   // State, datapath and all outputs are registered; reset abandons any frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shift       <= '0;
         byte_cnt    <= '0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
         last_served <= SEL_B;
         tx_data     <= 8'h00;
         tx_send     <= 1'b0;
         grant       <= 2'b00;
         done_a      <= 1'b0;
         done_b      <= 1'b0;
         err         <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_n;
         shift       <= shift_n;
         byte_cnt    <= byte_cnt_n;
         to_cnt      <= to_cnt_n;
         gap_cnt     <= gap_cnt_n;
         last_served <= last_n;
         tx_data     <= tx_data_n;
         tx_send     <= tx_send_n;
         grant       <= grant_n;
         done_a      <= done_a_n;
         done_b      <= done_b_n;
         err         <= err_n;
         active      <= active_n;
      end
   end

   // Next-state and next-output logic; pulses default low, data holds
   always_comb begin
      state_n    = state;
      shift_n    = shift;
      byte_cnt_n = byte_cnt;
      to_cnt_n   = to_cnt;
      gap_cnt_n  = gap_cnt;
      last_n     = last_served;
      tx_data_n  = tx_data;
      tx_send_n  = 1'b0;
      grant_n    = grant;
      done_a_n   = 1'b0;
      done_b_n   = 1'b0;
      err_n      = 1'b0;

      case (state)
         IDLE: begin
            if (req_a || req_b) begin
               // the frame is captured here; later input changes are ignored
               if (pick_a) begin
                  shift_n = frame_a;
                  grant_n = 2'b01;
               end else begin
                  shift_n = frame_b;
                  grant_n = 2'b10;
               end
               byte_cnt_n = '0;
               state_n    = SEND;
            end
         end

         SEND: begin
            if (!tx_busy) begin
               tx_data_n = shift[7:0];
               tx_send_n = 1'b1;
               to_cnt_n  = '0;
               state_n   = WAIT_BUSY;
            end
         end

         WAIT_BUSY: begin
            if (tx_busy) begin
               state_n = WAIT_DONE;
            end else if (to_cnt == TO_LAST) begin
               // transmitter never acknowledged: abort without a done pulse
               err_n     = 1'b1;
               grant_n   = 2'b00;
               last_n    = grant[1] ? SEL_B : SEL_A;
               gap_cnt_n = '0;
               state_n   = GAP;
            end else begin
               to_cnt_n = to_cnt + 1'b1;
            end
         end

         WAIT_DONE: begin
            if (!tx_busy) begin
               shift_n = shift >> 8;
               if (byte_cnt == BYTE_LAST) begin
                  byte_cnt_n = '0;
                  done_a_n   = grant[0];
                  done_b_n   = grant[1];
                  grant_n    = 2'b00;
                  last_n     = grant[1] ? SEL_B : SEL_A;
                  gap_cnt_n  = '0;
                  state_n    = GAP;
               end else begin
                  byte_cnt_n = byte_cnt + 1'b1;
                  state_n    = SEND;
               end
            end
         end

         GAP: begin
            if (gap_over) begin
               gap_cnt_n = '0;
               state_n   = IDLE;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
            end
         end

         default: begin
            grant_n = 2'b00;
            state_n = IDLE;
         end
      endcase

      active_n = (state_n != IDLE);
   end

   // Structural invariants of the output interface
   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_send_owned:   assert property (@(posedge clk) disable iff (reset) tx_send |-> (grant != 2'b00));
   a_send_single:  assert property (@(posedge clk) disable iff (reset) tx_send |=> !tx_send);

endmodule
